// File: rtl/video_timing_pkg.sv
// Shared types, default modes and the configuration legality check
// for the programmable video timing generator.
package video_timing_pkg;

   localparam int VT_XW = 12;
   localparam int VT_YW = 11;

   typedef struct packed {
      logic [VT_XW-1:0] h_active;
      logic [VT_XW-1:0] h_front;
      logic [VT_XW-1:0] h_sync;
      logic [VT_XW-1:0] h_back;
      logic [VT_YW-1:0] v_active;
      logic [VT_YW-1:0] v_front;
      logic [VT_YW-1:0] v_sync;
      logic [VT_YW-1:0] v_back;
      logic             hs_pol;
      logic             vs_pol;
   } vt_cfg_type;

   localparam vt_cfg_type VT_CFG_1366x768 = '{
      h_active: 12'd1366, h_front: 12'd70, h_sync: 12'd143, h_back: 12'd213,
      v_active: 11'd768,  v_front: 11'd3,  v_sync: 11'd5,   v_back: 11'd24,
      hs_pol:   1'b1,     vs_pol:  1'b1
   };

   localparam vt_cfg_type VT_CFG_TEST = '{
      h_active: 12'd8, h_front: 12'd2, h_sync: 12'd2, h_back: 12'd4,
      v_active: 11'd4, v_front: 11'd1, v_sync: 11'd1, v_back: 11'd2,
      hs_pol:   1'b1,  vs_pol:  1'b1
   };

   // ppc is a power of two, so alignment is a mask test on the OR of the fields.
   function automatic logic vt_cfg_check(input vt_cfg_type cfg, input int ppc);
      logic [VT_XW-1:0] mask;
      logic             nonzero;
      logic             aligned;
      mask    = VT_XW'(ppc - 1);
      nonzero = (cfg.h_active != '0) && (cfg.h_front != '0) &&
                (cfg.h_sync   != '0) && (cfg.h_back  != '0) &&
                (cfg.v_active != '0) && (cfg.v_front != '0) &&
                (cfg.v_sync   != '0) && (cfg.v_back  != '0);
      aligned = ((cfg.h_active | cfg.h_front | cfg.h_sync | cfg.h_back) & mask) == '0;
      return nonzero && aligned;
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: a wrapping counter with active and sync region decode.
// Used once per clock for the horizontal axis and once per line for the vertical.
module video_timing_axis #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         step,
   input  logic [W-1:0] last,
   input  logic [W-1:0] active_end,
   input  logic [W-1:0] sync_start,
   input  logic [W-1:0] sync_end,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (step)
         cnt <= wrap ? '0 : cnt + W'(1);
   end

   assign wrap   = (cnt == last);
   assign active = (cnt < active_end);
   assign sync   = (cnt >= sync_start) && (cnt < sync_end);

endmodule

// File: rtl/video_timing_gen.sv
// Programmable video timing generator: shadowed run-time modes applied on
// frame boundaries, per-mode sync polarity, 1/2/4 pixels per clock.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int         PPC     = 1,
   parameter int         XBITS   = 12,
   parameter int         YBITS   = 11,
   parameter vt_cfg_type DEF_CFG = VT_CFG_1366x768
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_cfg_valid,
   input  vt_cfg_type       i_cfg,
   output logic             o_cfg_pending,
   output logic             o_cfg_err,
   input  logic [YBITS-1:0] i_irq_line,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic [XBITS-1:0] o_x,
   output logic [YBITS-1:0] o_y,
   output logic [23:0]      o_xy_total,
   output logic             o_frame_start,
   output logic             o_line_irq,
   output logic [15:0]      o_frame_cnt
);

   localparam int SH = $clog2(PPC);
   localparam int HW = VT_XW + 2;
   localparam int VW = VT_YW + 2;

   vt_cfg_type    cfg;
   vt_cfg_type    shadow;
   logic          run;
   logic          idle;
   logic          live;
   logic          boundary;
   logic          cfg_ok;
   logic          accept;
   logic          apply;

   logic [HW-1:0] h_act_end, h_sync_start, h_sync_end, h_last, hc;
   logic [VW-1:0] v_act_end, v_sync_start, v_sync_end, v_last, vc;
   logic          h_wrap, h_act, h_sync, v_wrap, v_act, v_sync;
   logic          de_d, hs_d, vs_d, first_d, irq_d;

   // Region boundaries in counter units (clocks horizontally, lines vertically).
   always_comb begin
      h_act_end    = HW'(cfg.h_active) >> SH;
      h_sync_start = (HW'(cfg.h_active) + HW'(cfg.h_front)) >> SH;
      h_sync_end   = (HW'(cfg.h_active) + HW'(cfg.h_front) + HW'(cfg.h_sync)) >> SH;
      h_last       = ((HW'(cfg.h_active) + HW'(cfg.h_front) + HW'(cfg.h_sync) +
                       HW'(cfg.h_back)) >> SH) - HW'(1);
      v_act_end    = VW'(cfg.v_active);
      v_sync_start = VW'(cfg.v_active) + VW'(cfg.v_front);
      v_sync_end   = VW'(cfg.v_active) + VW'(cfg.v_front) + VW'(cfg.v_sync);
      v_last       = VW'(cfg.v_active) + VW'(cfg.v_front) + VW'(cfg.v_sync) +
                     VW'(cfg.v_back) - VW'(1);
   end

   // run delays enable by one cycle so the first line starts from a settled hc = 0.
   assign idle = ~i_enable;
   assign live = i_enable & run;

   video_timing_axis #(.W(HW)) h_axis (
      .clk        (i_clk),
      .rst        (i_rst),
      .clear      (idle),
      .step       (live),
      .last       (h_last),
      .active_end (h_act_end),
      .sync_start (h_sync_start),
      .sync_end   (h_sync_end),
      .cnt        (hc),
      .wrap       (h_wrap),
      .active     (h_act),
      .sync       (h_sync)
   );

   video_timing_axis #(.W(VW)) v_axis (
      .clk        (i_clk),
      .rst        (i_rst),
      .clear      (idle),
      .step       (live & h_wrap),
      .last       (v_last),
      .active_end (v_act_end),
      .sync_start (v_sync_start),
      .sync_end   (v_sync_end),
      .cnt        (vc),
      .wrap       (v_wrap),
      .active     (v_act),
      .sync       (v_sync)
   );

   // NOTE: every signal driven here is fully assigned on every pass, so no
   // latch can be inferred.
   always_comb begin
      boundary = live & h_wrap & v_wrap;
      cfg_ok   = vt_cfg_check(i_cfg, PPC);
      accept   = i_cfg_valid & cfg_ok;
      apply    = o_cfg_pending & (idle | boundary);
      de_d     = live & h_act & v_act;
      hs_d     = live & h_sync;
      vs_d     = live & v_sync;
      first_d  = live & (hc == '0) & (vc == '0);
      irq_d    = live & (hc == '0) & (vc == VW'(i_irq_line)) & (VW'(i_irq_line) <= v_last);
   end

   // NOTE: the mode registers are reset to DEF_CFG because the counters decode
   // them straight out of reset; they are control state, not bulk storage.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cfg           <= DEF_CFG;
         shadow        <= DEF_CFG;
         o_cfg_pending <= 1'b0;
         o_cfg_err     <= 1'b0;
      end else begin
         o_cfg_err <= i_cfg_valid & ~cfg_ok;
         if (apply)
            cfg <= shadow;
         // A request landing on the apply cycle stays pending for the next boundary.
         if (accept) begin
            shadow        <= i_cfg;
            o_cfg_pending <= 1'b1;
         end else if (apply) begin
            o_cfg_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         run           <= 1'b0;
         o_de          <= 1'b0;
         o_hsync       <= ~DEF_CFG.hs_pol;
         o_vsync       <= ~DEF_CFG.vs_pol;
         o_x           <= '0;
         o_y           <= '0;
         o_xy_total    <= '0;
         o_frame_start <= 1'b0;
         o_line_irq    <= 1'b0;
         o_frame_cnt   <= '0;
      end else begin
         run           <= i_enable;
         o_de          <= de_d;
         o_hsync       <= ~(hs_d ^ cfg.hs_pol);
         o_vsync       <= ~(vs_d ^ cfg.vs_pol);
         o_x           <= de_d ? XBITS'(hc << SH) : '0;
         o_y           <= (live & v_act) ? YBITS'(vc) : '0;
         o_frame_start <= first_d;
         o_line_irq    <= irq_d;
         if (idle)
            o_xy_total <= '0;
         else if (de_d)
            o_xy_total <= first_d ? '0 : o_xy_total + 24'(PPC);
         if (boundary)
            o_frame_cnt <= o_frame_cnt + 16'd1;
      end
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable, parametrised video timing generator for the HDMI pipeline; the next generation of the fixed-mode sync stage that drives the framebuffer and colour-conversion stages. It differs from the fixed stage in three ways:
- Timings are loaded at run time through a shadow-register handshake and applied only on frame boundaries.
- Sync polarity is per-mode.
- It emits 1, 2 or 4 pixels per clock and raises frame-start and programmable line interrupts.

## Interface
Parameters:
- PPC, 1 — pixels per clock; legal values 1, 2, 4.
- XBITS, 12 — width of horizontal timing fields and o_x.
- YBITS, 11 — width of vertical timing fields and o_y.
- DEF_CFG, video_timing_pkg::VT_CFG_1366x768 — mode active after reset: 1366/70/143/213, 768/3/5/24, both syncs active-high.

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  pixel clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_enable  in  1  run timing; low holds the generator idle.
- i_cfg_valid  in  1  request to load i_cfg into the shadow register.
- i_cfg  in  vt_cfg_type  mode: h_active, h_front, h_sync, h_back (XBITS each); v_active, v_front, v_sync, v_back (YBITS each); hs_pol, vs_pol.
- o_cfg_pending  out  1  a shadow configuration is waiting for the frame boundary.
- o_cfg_err  out  1  one-cycle pulse when a request is rejected.
- i_irq_line  in  YBITS  line number that fires o_line_irq.
- o_hsync  out  1  horizontal sync, polarity per hs_pol.
- o_vsync  out  1  vertical sync, polarity per vs_pol.
- o_de  out  1  data enable.
- o_x  out  XBITS  first pixel index of the current beat.
- o_y  out  YBITS  active line index.
- o_xy_total  out  24  linear index of the first pixel, y*h_active + x.
- o_frame_start  out  1  pulse on the first active beat of a frame.
- o_line_irq  out  1  pulse at the start of line i_irq_line.
- o_frame_cnt  out  16  completed-frame counter; wraps at 65535 -> 0.

## Operation
- Horizontal counter hc counts 0..HT-1, with HT = (h_active+h_front+h_sync+h_back)/PPC. Vertical counter vc counts 0..VT-1 and advances when hc == HT-1.
- Region order is active, front, sync, back on both axes.
- Decode, in clocks/lines:
  - de = hc < h_active/PPC and vc < v_active.
  - hsync is active for (h_active+h_front)/PPC <= hc < (h_active+h_front+h_sync)/PPC.
  - vsync is active for v_active+v_front <= vc < v_active+v_front+v_sync.
- Output level: o_hsync = hsync_active XNOR hs_pol; o_vsync is formed the same way with vs_pol.
- o_x = hc*PPC while de, else 0. o_y = vc while vc < v_active, else 0.
- o_xy_total:
  - increments by PPC on every de beat;
  - is 0 on the first beat of a frame;
  - holds its value outside de.
- Config accept:
  - i_cfg_valid is sampled every cycle.
  - Rejected with o_cfg_err if any field is 0, or if any horizontal field is not a multiple of PPC; the shadow and pending state are unchanged.
  - Otherwise i_cfg goes to the shadow and o_cfg_pending is set. A newer valid request overwrites the shadow.
- Config apply:
  - applied in the cycle where hc == HT-1 and vc == VT-1, or in any cycle while i_enable is low;
  - the active config is updated and o_cfg_pending clears;
  - an apply and a new accept in the same cycle: the new request stays pending.
- Enable:
  - i_enable low: hc = vc = 0, o_de = 0, syncs at inactive level, o_xy_total = 0.
  - Low mid-frame aborts the frame immediately; o_frame_cnt is not incremented.
- o_frame_cnt increments on the apply-boundary cycle (hc == HT-1, vc == VT-1).
- o_line_irq fires when hc == 0, vc == i_irq_line, and i_irq_line < VT.

## Timing
- Reset values: hc = vc = 0; active config = DEF_CFG; o_de = 0; o_hsync = ~DEF_CFG.hs_pol; o_vsync = ~DEF_CFG.vs_pol; all other outputs 0.
- All outputs are registered and show the decode of the counter value from the previous cycle (latency 1).
- After i_enable rises, the first o_de and o_frame_start appear 2 cycles later (counter step, then register).
- A config that is accepted while enabled takes effect on the first beat of the next frame.

## Structure
- Package video_timing_pkg holds:
  - vt_cfg_type (struct);
  - VT_CFG_1366x768 and a VT_CFG_TEST small-mode constant;
  - the function vt_cfg_check(cfg, ppc) returning a valid bit.
- Sub-module video_timing_axis: one counter plus region decode, parameterised by width. It is instantiated once for the horizontal axis and once for the vertical axis, with a step-enable input.

## Test plan
- PPC=1, VT_CFG_TEST (8/2/2/4, 4/1/1/2, pol=1) -> HT=16, VT=8; 32 o_de cycles per 128-cycle frame; o_hsync high at hc 10..11; o_xy_total ends at 31.
- PPC=2, horizontal 8/2/2/4 -> HT=8; 4 de beats per line; o_x = 0,2,4,6; o_xy_total advances by 2.
- Accept a new config (h_active=12) mid-frame -> o_cfg_pending = 1 until the frame boundary; the next frame shows 12 active pixels; o_frame_cnt = 1.
- h_sync = 0, or h_front = 3 with PPC=2 -> o_cfg_err pulses once; o_cfg_pending and the active timing are unchanged.
- i_irq_line = 2 -> one o_line_irq per frame, on the cycle after hc = 0, vc = 2. i_irq_line = 9 -> no pulse.
- Assert i_rst, or drop i_enable, at hc = 5, vc = 1 -> outputs idle next cycle (syncs inactive per polarity); after re-enable, o_frame_start appears 2 cycles later with o_xy_total = 0.
